// File: rtl/seq_divider.sv
// Sequential 32-bit signed divider with MIPS div semantics.
// A restoring divider on operand magnitudes takes 32 steps, then a FIX cycle applies the signs.
module seq_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        DivCtrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        DivZero,
  output logic        DivStop,
  output logic [31:0] DivHOut,
  output logic [31:0] DivLOut,
  output logic        Busy
);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] b_q, b_d;
  logic        asign_q, asign_d;
  logic        qsign_q, qsign_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        zero_q, zero_d;
  logic        stop_q, stop_d;

  logic [32:0] shifted;
  logic [32:0] trial;

  // The partial remainder stays below |B| <= 2^31, so a 33-bit trial never overflows.
  assign shifted = {1'b0, rem_q[30:0], quo_q[31]} | {rem_q[31], 32'd0};
  assign trial   = shifted - {1'b0, b_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    b_d     = b_q;
    asign_d = asign_q;
    qsign_d = qsign_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    zero_d  = 1'b0;
    stop_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (DivCtrl) begin
          if (B == 32'd0) begin
            zero_d = 1'b1;
          end else begin
            quo_d   = A[31] ? (~A + 32'd1) : A;
            b_d     = B[31] ? (~B + 32'd1) : B;
            rem_d   = 32'd0;
            asign_d = A[31];
            qsign_d = A[31] ^ B[31];
            cnt_d   = 6'd0;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (!trial[32]) begin
          rem_d = trial[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = shifted[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = StFix;
        end
      end
      StFix: begin
        lo_d    = qsign_q ? (~quo_q + 32'd1) : quo_q;
        hi_d    = asign_q ? (~rem_q + 32'd1) : rem_q;
        stop_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 6'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      b_q     <= 32'd0;
      asign_q <= 1'b0;
      qsign_q <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      zero_q  <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      b_q     <= b_d;
      asign_q <= asign_d;
      qsign_q <= qsign_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      zero_q  <= zero_d;
      stop_q  <= stop_d;
    end
  end

  assign DivZero = zero_q;
  assign DivStop = stop_q;
  assign DivHOut = hi_q;
  assign DivLOut = lo_q;
  // FIX returns to idle on the same edge that raises DivStop, so Busy covers that cycle via stop_q.
  assign Busy    = (state_q != StIdle) | stop_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed operands with hand-computed results,
// a negedge monitor pops expectations whenever DivStop or DivZero fires.
module tb_seq_divider;

  logic        clk;
  logic        reset;
  logic        DivCtrl;
  logic [31:0] A;
  logic [31:0] B;
  logic        DivZero;
  logic        DivStop;
  logic [31:0] DivHOut;
  logic [31:0] DivLOut;
  logic        Busy;

  seq_divider dut (
    .clk     (clk),
    .reset   (reset),
    .DivCtrl (DivCtrl),
    .A       (A),
    .B       (B),
    .DivZero (DivZero),
    .DivStop (DivStop),
    .DivHOut (DivHOut),
    .DivLOut (DivLOut),
    .Busy    (Busy)
  );

  typedef struct packed {
    logic        zero;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;
  int   stops;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!reset && (DivStop || DivZero)) begin
      check("stop_zero_exclusive", {64'd0, DivStop & DivZero}, 65'd0);
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got zero=%b stop=%b hi=%h lo=%h expected none",
                 DivZero, DivStop, DivHOut, DivLOut);
      end else begin
        mon_e = sb.pop_front();
        check("result", {DivZero, DivHOut, DivLOut}, mon_e);
      end
    end
  end

  task automatic start(input logic [31:0] a, input logic [31:0] b, input bit push,
                       input logic [31:0] ehi, input logic [31:0] elo);
    @(negedge clk);
    A       = a;
    B       = b;
    DivCtrl = 1'b1;
    if (push) sb.push_back({(b == 32'd0), ehi, elo});
    @(posedge clk);
    #1 DivCtrl = 1'b0;
  endtask

  // Waits for DivStop; 'already' is the number of edges elapsed since the accepting edge.
  task automatic wait_done(input int already, input bit chk_after);
    int k;
    bit seen;
    bit busy_ok;
    seen    = 1'b0;
    busy_ok = 1'b1;
    k       = already;
    while (!seen && k < 60) begin
      @(posedge clk);
      #1;
      k++;
      if (DivStop) seen = 1'b1;
      if (!Busy) busy_ok = 1'b0;
    end
    check("done_seen", {64'd0, seen}, 65'd1);
    check("latency", 65'(k), 65'd33);
    check("busy_during_op", {64'd0, busy_ok}, 65'd1);
    if (chk_after) begin
      @(posedge clk);
      #1 check("busy_after_stop", {63'd0, Busy, DivStop}, 65'd0);
    end
  endtask

  initial begin
    reset   = 1'b1;
    DivCtrl = 1'b0;
    A       = 32'd0;
    B       = 32'd0;
    #2;
    check("reset_state", {DivHOut, DivLOut, DivZero, DivStop, Busy}, 65'd0);
    @(negedge clk);
    reset = 1'b0;

    start(32'd7, 32'hFFFF_FFFE, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD);
    wait_done(0, 1'b1);
    start(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_done(0, 1'b1);
    start(32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
    wait_done(0, 1'b1);
    start(32'd7, 32'd2, 1'b1, 32'd1, 32'd3);
    wait_done(0, 1'b1);

    // Divide by zero: flag only, outputs keep 1/3.
    start(32'd5, 32'd0, 1'b1, 32'd1, 32'd3);
    check("zero_pulse", {63'd0, Busy, DivZero}, 65'd1);
    @(posedge clk);
    #1 check("zero_one_cycle", {63'd0, DivZero, Busy}, 65'd0);
    check("hold_after_zero", {1'b0, DivHOut, DivLOut}, {1'b0, 32'd1, 32'd3});

    start(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000);
    wait_done(0, 1'b1);

    // DivCtrl with B=0 mid-run must be ignored.
    start(32'd9, 32'd4, 1'b1, 32'd1, 32'd2);
    repeat (4) @(posedge clk);
    @(negedge clk);
    A       = 32'd1;
    B       = 32'd0;
    DivCtrl = 1'b1;
    @(posedge clk);
    #1 DivCtrl = 1'b0;
    wait_done(5, 1'b1);

    // Held DivCtrl restarts at E34.
    @(negedge clk);
    A       = 32'd20;
    B       = 32'd3;
    DivCtrl = 1'b1;
    sb.push_back({1'b0, 32'd2, 32'd6});
    sb.push_back({1'b0, 32'd2, 32'd6});
    @(posedge clk);
    #1;
    wait_done(0, 1'b0);
    @(posedge clk);
    #1 check("restart_busy", {63'd0, Busy, DivStop}, 65'd2);
    DivCtrl = 1'b0;
    wait_done(0, 1'b1);

    // Reset mid-run aborts with no DivStop.
    start(32'd100, 32'd7, 1'b0, 32'd0, 32'd0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 check("async_reset", {DivHOut, DivLOut, DivZero, DivStop, Busy}, 65'd0);
    @(negedge clk);
    reset = 1'b0;
    stops = 0;
    repeat (40) begin
      @(negedge clk);
      if (DivStop) stops++;
    end
    check("no_stop_after_abort", 65'(stops), 65'd0);
    start(32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
    wait_done(0, 1'b1);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 65'(sb.size()), 65'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset; forces the reset state immediately, independent of clk.
REQ-003 DivCtrl  input  1  start request from the control unit; sampled on rising clk.
REQ-004 A  input  32  dividend, two's complement; sampled only at the accepting edge.
REQ-005 B  input  32  divisor, two's complement; sampled only at the accepting edge.
REQ-006 DivZero  output  1  one-cycle pulse flagging an attempted divide by zero.
REQ-007 DivStop  output  1  one-cycle completion pulse; HI/LO valid while high and held afterwards.
REQ-008 DivHOut  output  32  remainder (HI source).
REQ-009 DivLOut  output  32  quotient (LO source).
REQ-010 Busy  output  1  high from accept until the DivStop cycle, inclusive.

Function
REQ-011 The FSM SHALL have states IDLE, RUN, FIX; reset state IDLE.
REQ-012 In IDLE with DivCtrl=1 and B!=0 at edge E0, the block SHALL latch |A|, |B|, sign(A), sign(A)^sign(B), clear a 6-bit step counter, and enter RUN.
REQ-013 In IDLE with DivCtrl=1 and B==0 at E0, the block SHALL stay IDLE, leave DivHOut/DivLOut unchanged, assert DivZero for the single cycle after E0, and never assert DivStop.
REQ-014 In RUN, each edge (E1..E32) SHALL perform one restoring step: shift {rem,quo} left 1, trial-subtract |B| from the 33-bit partial remainder, keep the result and set quotient bit 1 if non-negative, else restore and set bit 0.
REQ-015 After the 32nd step (counter = 31 at E32) the FSM SHALL enter FIX.
REQ-016 At E33 (FIX), the block SHALL register DivLOut = quotient magnitude negated if the quotient sign is 1, DivHOut = remainder magnitude negated if sign(A) = 1, assert DivStop for exactly the cycle E33..E34, and return to IDLE.
REQ-017 Total latency SHALL be 33 cycles from the accepting edge to the DivStop cycle; a new start is accepted at E34 at the earliest.
REQ-018 Semantics SHALL be MIPS div: quotient truncates toward zero; remainder takes the sign of the dividend; A = quotient*B + remainder (mod 2^32).
REQ-019 Magnitudes SHALL use 32-bit unsigned wrap: |0x80000000| = 0x80000000; 0x80000000 / 0xFFFFFFFF SHALL yield DivLOut = 0x80000000, DivHOut = 0, no flag.
REQ-020 DivCtrl during RUN or FIX SHALL be ignored (no restart, no operand resample, no DivZero).
REQ-021 DivCtrl held high continuously SHALL start exactly one operation per IDLE visit; the block SHALL restart at E34 if DivCtrl is still high there.
REQ-022 DivHOut/DivLOut SHALL change only at the FIX edge or on reset; they SHALL hold their value across IDLE and RUN.
REQ-023 DivZero and DivStop SHALL be registered outputs and never high in the same cycle.

Reset
REQ-024 Reset SHALL drive state IDLE, counter 0, all internal registers 0, DivHOut = 0, DivLOut = 0, DivZero = 0, DivStop = 0, Busy = 0.
REQ-025 Reset asserted mid-RUN or mid-FIX SHALL abort the operation with no DivStop; after deassertion a start at the next edge SHALL be accepted normally.

Verification
REQ-026 A=7, B=2, start at E0 -> Busy high E0..E34, DivStop high only after E33, DivLOut=0x00000003, DivHOut=0x00000001.
REQ-027 A=0xFFFFFFF9 (-7), B=2 -> DivLOut=0xFFFFFFFD, DivHOut=0xFFFFFFFF; A=7, B=0xFFFFFFFE -> DivLOut=0xFFFFFFFD, DivHOut=0x00000001.
REQ-028 DivHOut/DivLOut preloaded via 7/2, then A=5, B=0 -> DivZero one cycle after E0, DivStop stays 0, Busy stays 0, outputs stay 1/3.
REQ-029 A=0x80000000, B=0xFFFFFFFF -> DivLOut=0x80000000, DivHOut=0x00000000, DivZero=0.
REQ-030 Start 100/7, pulse reset at E10 between edges -> all outputs 0 immediately, no DivStop; start 100/7 after release -> DivLOut=14, DivHOut=2 after 33 cycles.
REQ-031 Start 9/4, reassert DivCtrl with A=1, B=0 at E5 -> no DivZero, result DivLOut=2, DivHOut=1 at the normal DivStop cycle.
